// File: rtl/fc3_bs_pkg.sv
// Shared types for the fc3 bitstream accumulator array: FSM state encoding
// and the output-width helper.
package fc3_bs_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    // The count must hold the full-window value 2^cwid, hence one extra bit.
    function automatic int owid_of(input int cwid);
        return cwid + 1;
    endfunction

endpackage

// File: rtl/fc3_bs_acc_ch.sv
// One channel of the bitstream accumulator: a running count plus its slice of
// the output register.
module fc3_bs_acc_ch #(
    parameter int OWID = 11
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            add,
    input  logic            load,
    input  logic            bs,
    output logic [OWID-1:0] out_q
);

    logic [OWID-1:0] acc_q;
    logic [OWID-1:0] sum;

    // With add low (HOLD) this is simply the frozen count, so one load path
    // serves both the direct end-of-window load and the release from HOLD.
    assign sum = acc_q + {{(OWID-1){1'b0}}, add & bs};

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            out_q <= '0;
        end else begin
            if (clear) begin
                acc_q <= '0;
            end else if (add) begin
                acc_q <= sum;
            end
            if (load) begin
                out_q <= sum;
            end
        end
    end

endmodule

// File: rtl/fc3_bs_acc_array.sv
// Parallel unary-to-binary decoder: counts NCH bitstreams over 2^CWID enabled
// cycles and presents the counts through a registered valid/ready output.
module fc3_bs_acc_array
    import fc3_bs_pkg::*;
#(
    parameter int CWID = 10,
    parameter int NCH  = 32,
    parameter int OWID = owid_of(CWID)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                start,
    input  logic [NCH-1:0]      bsIn,
    output logic                busy,
    output logic [NCH*OWID-1:0] accOut,
    output logic                outValid,
    input  logic                outReady,
    output logic [1:0]          dbg_state
);

    state_t          state;
    logic [CWID-1:0] win_cnt;
    logic            xfer;
    logic            sample;
    logic            last;
    logic            clear;
    logic            load;

    // Handshake: accOut is consumed on any edge with outValid && outReady; the
    // slot is free (xfer) when empty or being consumed on that same edge, and
    // a load then overwrites it while outValid stays high.
    always_comb begin
        xfer   = !outValid || outReady;
        sample = (state == ACC) && enable;
        last   = sample && (win_cnt == {CWID{1'b1}});
        clear  = (state == IDLE) && start;
        load   = xfer && (last || (state == HOLD));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            win_cnt  <= '0;
            outValid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= ACC;
                        win_cnt <= '0;
                    end
                end
                ACC: begin
                    if (sample) begin
                        win_cnt <= win_cnt + CWID'(1);
                        if (last) begin
                            state <= xfer ? IDLE : HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (xfer) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            if (load) begin
                outValid <= 1'b1;
            end else if (outReady) begin
                outValid <= 1'b0;
            end
        end
    end

    assign busy      = (state != IDLE);
    assign dbg_state = state;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        fc3_bs_acc_ch #(.OWID(OWID)) u_ch (
            .clk   (clk),
            .rst   (rst),
            .clear (clear),
            .add   (sample),
            .load  (load),
            .bs    (bsIn[i]),
            .out_q (accOut[i*OWID +: OWID])
        );
    end

endmodule
